// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared constants and types for the fetch PC redirect controller.
// Holds the boot address, epoch width, controller states and redirect-source encoding.
package pc_redirect_ctrl_pkg;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;
   localparam int unsigned EPOCH_W  = 2;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_IDLE = 2'd2
   } state_e;

   // Winning redirect source for the current cycle, highest priority first.
   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_EXCP = 3'd1,
      SRC_BR   = 3'd2,
      SRC_IDLE = 3'd3,
      SRC_BP   = 3'd4,
      SRC_SEQ  = 3'd5
   } redir_src_e;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

   function automatic logic flushes_pipe(input redir_src_e src);
      return (src == SRC_EXCP) || (src == SRC_BR);
   endfunction

endpackage : pc_redirect_ctrl_pkg

// File: rtl/pc_redirect_ctrl.sv
// Next-fetch-PC controller: selects between exception, branch, idle, predicted and
// sequential targets, sequences BOOT/RUN/IDLE, and stamps requests with a flush epoch.
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = pc_redirect_ctrl_pkg::RESET_PC
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 excp_valid_i,
   input  logic [31:0]          excp_target_i,
   input  logic                 br_valid_i,
   input  logic [31:0]          br_target_i,
   input  logic                 bp_taken_i,
   input  logic [31:0]          bp_target_i,
   input  logic                 idle_valid_i,
   input  logic [31:0]          idle_target_i,
   input  logic                 intr_i,
   input  logic                 fetch_ready_i,
   output logic                 fetch_valid_o,
   output logic [31:0]          pc_o,
   output logic [EPOCH_W-1:0]   epoch_o,
   output logic                 idle_o
);

   state_e               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [EPOCH_W-1:0]   epoch_q, epoch_d;
   logic                 fetch_valid_q, fetch_valid_d;
   logic                 idle_q, idle_d;

   redir_src_e           src;
   logic                 accept;

   assign accept = fetch_valid_q & fetch_ready_i;

   // Priority select: only the single highest-priority source legal in this state wins.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      src = SRC_NONE;
      unique case (state_q)
         ST_RUN: begin
            if (excp_valid_i)            src = SRC_EXCP;
            else if (br_valid_i)         src = SRC_BR;
            else if (idle_valid_i)       src = SRC_IDLE;
            else if (accept && bp_taken_i) src = SRC_BP;
            else if (accept)             src = SRC_SEQ;
         end
         ST_IDLE: begin
            if (excp_valid_i)            src = SRC_EXCP;
         end
         default: src = SRC_NONE;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epoch_d = epoch_q;

      unique case (src)
         SRC_EXCP: pc_d = excp_target_i;
         SRC_BR:   pc_d = br_target_i;
         SRC_IDLE: pc_d = idle_target_i;
         SRC_BP:   pc_d = bp_target_i;
         SRC_SEQ:  pc_d = seq_pc(pc_q);
         default:  pc_d = pc_q;
      endcase

      // Simultaneous exception and branch collapse into one source, hence one bump.
      if (flushes_pipe(src)) begin
         epoch_d = epoch_q + EPOCH_W'(1);
      end

      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (src == SRC_IDLE) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (src == SRC_EXCP || intr_i) state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase

      // Outputs are registered from the next state so they never see inputs combinationally.
      fetch_valid_d = (state_d == ST_RUN);
      idle_d        = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here, so it lives inside the clocked branch and wins
      // over every redirect input sampled on the same edge.
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         epoch_q       <= '0;
         fetch_valid_q <= 1'b0;
         idle_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         state_q       <= state_d;
         pc_q          <= pc_d;
         epoch_q       <= epoch_d;
         fetch_valid_q <= fetch_valid_d;
         idle_q        <= idle_d;
      end
   end

   assign fetch_valid_o = fetch_valid_q;
   assign pc_o          = pc_q;
   assign epoch_o       = epoch_q;
   assign idle_o        = idle_q;

endmodule : pc_redirect_ctrl

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        excp_valid_i, br_valid_i, bp_taken_i, idle_valid_i, intr_i, fetch_ready_i;
   logic [31:0] excp_target_i, br_target_i, bp_target_i, idle_target_i;
   logic        fetch_valid_o, idle_o;
   logic [31:0] pc_o;
   logic [1:0]  epoch_o;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: plain flags and integers derived from the redirect rules.
   logic [31:0] m_pc;
   int          m_epoch;
   bit          m_boot;
   bit          m_idle;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .excp_valid_i  (excp_valid_i),
      .excp_target_i (excp_target_i),
      .br_valid_i    (br_valid_i),
      .br_target_i   (br_target_i),
      .bp_taken_i    (bp_taken_i),
      .bp_target_i   (bp_target_i),
      .idle_valid_i  (idle_valid_i),
      .idle_target_i (idle_target_i),
      .intr_i        (intr_i),
      .fetch_ready_i (fetch_ready_i),
      .fetch_valid_o (fetch_valid_o),
      .pc_o          (pc_o),
      .epoch_o       (epoch_o),
      .idle_o        (idle_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pc"},    pc_o,                 m_pc);
      check({tag, ".epoch"}, {30'd0, epoch_o},     32'(m_epoch));
      check({tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, !m_boot && !m_idle});
      check({tag, ".idle"},  {31'd0, idle_o},      {31'd0, m_idle});
   endtask

   // Applies the inputs currently driven to the model, as the next clock edge will.
   function automatic void model_step();
      bit running;
      running = !m_boot && !m_idle;
      if (rst) begin
         m_pc = 32'h1c00_0000; m_epoch = 0; m_boot = 1; m_idle = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (excp_valid_i) begin
         m_pc = excp_target_i; m_epoch = (m_epoch + 1) % 4; m_idle = 0;
      end else if (m_idle) begin
         if (intr_i) m_idle = 0;
      end else if (running) begin
         if (br_valid_i) begin
            m_pc = br_target_i; m_epoch = (m_epoch + 1) % 4;
         end else if (idle_valid_i) begin
            m_pc = idle_target_i; m_idle = 1;
         end else if (fetch_ready_i) begin
            m_pc = bp_taken_i ? bp_target_i : m_pc + 32'd4;
         end
      end
   endfunction

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic clear_inputs();
      rst = 1'b0; excp_valid_i = 1'b0; br_valid_i = 1'b0; bp_taken_i = 1'b0;
      idle_valid_i = 1'b0; intr_i = 1'b0; fetch_ready_i = 1'b0;
      excp_target_i = '0; br_target_i = '0; bp_target_i = '0; idle_target_i = '0;
   endtask

   initial begin
      m_pc = '0; m_epoch = 0; m_boot = 1; m_idle = 0;
      clear_inputs();

      // Reset and boot bubble, then sequential fetch.
      rst = 1'b1;
      cycle("reset");
      check("reset.pc_const", pc_o, 32'h1c00_0000);
      rst = 1'b0; fetch_ready_i = 1'b1;
      cycle("boot");
      check("boot.pc_const", pc_o, 32'h1c00_0000);
      cycle("seq1");
      check("seq1.pc_const", pc_o, 32'h1c00_0004);
      cycle("seq2");
      check("seq2.pc_const", pc_o, 32'h1c00_0008);

      // Branch redirect while fetch is stalled.
      fetch_ready_i = 1'b0; br_valid_i = 1'b1; br_target_i = 32'h1c00_0100;
      cycle("br_stall");
      check("br_stall.pc_const", pc_o, 32'h1c00_0100);
      check("br_stall.epoch_const", {30'd0, epoch_o}, 32'd1);

      // Exception and branch together: exception wins, single epoch bump.
      excp_valid_i = 1'b1; excp_target_i = 32'h1c00_8000; br_target_i = 32'h1c00_0200;
      cycle("excp_br");
      check("excp_br.epoch_const", {30'd0, epoch_o}, 32'd2);
      excp_valid_i = 1'b0; br_valid_i = 1'b0;

      // Enter IDLE, hold there, then wake on interrupt.
      fetch_ready_i = 1'b1; idle_valid_i = 1'b1; idle_target_i = 32'h1c00_0040;
      cycle("idle_enter");
      idle_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bp_taken_i = 1'(i & 1); bp_target_i = 32'h0bad_0000;
         br_valid_i = 1'(i == 3); br_target_i = 32'h0bad_1000;
         cycle($sformatf("idle_hold%0d", i));
      end
      bp_taken_i = 1'b0; br_valid_i = 1'b0; intr_i = 1'b1;
      cycle("idle_wake");
      check("idle_wake.pc_const", pc_o, 32'h1c00_0040);
      intr_i = 1'b0;

      // Wrap at the top of the address space, then a predicted-taken accept.
      br_valid_i = 1'b1; br_target_i = 32'hffff_fffc;
      cycle("br_top");
      br_valid_i = 1'b0;
      cycle("wrap");
      check("wrap.pc_const", pc_o, 32'h0000_0000);
      bp_taken_i = 1'b1; bp_target_i = 32'h1c00_0010;
      cycle("bp_taken");
      check("bp_taken.pc_const", pc_o, 32'h1c00_0010);
      bp_taken_i = 1'b0;

      // Misaligned target passes through unchanged.
      br_valid_i = 1'b1; br_target_i = 32'h1c00_0123;
      cycle("misalign");
      br_valid_i = 1'b0;

      // Reset overrides an exception while idling.
      idle_valid_i = 1'b1; idle_target_i = 32'h1c00_0080;
      cycle("idle_again");
      idle_valid_i = 1'b0;
      rst = 1'b1; excp_valid_i = 1'b1; excp_target_i = 32'h1c00_9000;
      cycle("rst_in_idle");
      check("rst_in_idle.epoch_const", {30'd0, epoch_o}, 32'd0);
      rst = 1'b0;
      cycle("boot_excp_ignored");
      excp_valid_i = 1'b0;
      cycle("post_boot");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         excp_valid_i  = ($urandom_range(0, 15) == 0);
         br_valid_i    = ($urandom_range(0, 9) == 0);
         idle_valid_i  = ($urandom_range(0, 24) == 0);
         intr_i        = ($urandom_range(0, 7) == 0);
         fetch_ready_i = ($urandom_range(0, 3) != 0);
         bp_taken_i    = ($urandom_range(0, 3) == 0);
         excp_target_i = $urandom;
         br_target_i   = ($urandom_range(0, 7) == 0) ? 32'hffff_fff8 : $urandom;
         bp_target_i   = $urandom;
         idle_target_i = $urandom;
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_pc_redirect_ctrl

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h1c00_0000, is the first fetch address after reset.
REQ-003 Port clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Port excp_valid_i / excp_target_i  in  1/32  exception or ertn redirect.
REQ-006 Port br_valid_i / br_target_i  in  1/32  backend branch-mispredict redirect.
REQ-007 Port bp_taken_i / bp_target_i  in  1/32  BPU prediction for the current pc_o, same cycle.
REQ-008 Port idle_valid_i / idle_target_i  in  1/32  IDLE committed; target is the resume PC.
REQ-009 Port intr_i  in  1  pending-interrupt wake.
REQ-010 Port fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
REQ-011 Port fetch_valid_o / pc_o  out  1/32  fetch request and its address.
REQ-012 Port epoch_o  out  2  flush epoch stamped on each fetch request.
REQ-013 Port idle_o  out  1  high while in IDLE state.

Function
REQ-014 SHALL implement states BOOT, RUN, IDLE.
- BOOT: fetch_valid_o=0 for exactly one cycle after reset release, then RUN.
- RUN: fetch_valid_o=1.
- IDLE: fetch_valid_o=0 and idle_o=1.
REQ-015 Accept = fetch_valid_o & fetch_ready_i.
- pc_o SHALL hold whenever no accept and no redirect occur.
REQ-016 Redirect priority SHALL be excp > br > idle > bp > sequential.
- Only the highest-priority source applies.
REQ-017 excp_valid_i SHALL load pc_o <= excp_target_i next cycle in any non-BOOT state, regardless of fetch_ready_i.
- An unaccepted request is dropped.
- IDLE exits to RUN.
REQ-018 br_valid_i (no excp) SHALL load pc_o <= br_target_i next cycle in RUN, regardless of fetch_ready_i.
REQ-019 idle_valid_i (no excp/br) in RUN SHALL load pc_o <= idle_target_i and enter IDLE next cycle.
REQ-020 IDLE SHALL exit to RUN on intr_i.
- pc_o keeps idle_target_i.
- fetch_valid_o=1 the following cycle.
REQ-021 br_valid_i and idle_valid_i SHALL be ignored in IDLE and BOOT.
- excp_valid_i SHALL be ignored in BOOT.
REQ-022 bp_taken_i SHALL apply only on accept with no higher-priority source: pc_o <= bp_target_i.
REQ-023 Sequential step on accept with no redirect: pc_o <= pc_o + 4, modulo 2^32.
- 32'hffff_fffc wraps to 0.
REQ-024 Target low bits SHALL pass unchanged (misalignment is flagged downstream).
REQ-025 epoch_o SHALL increment modulo 4 on every applied excp or br redirect.
- Idle/bp/sequential steps SHALL not change epoch_o.
- Simultaneous excp and br SHALL count as one increment.
REQ-026 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-027 On rst the block SHALL set:
- pc_o=RESET_PC, epoch_o=0, state=BOOT.
- fetch_valid_o=0, idle_o=0.
REQ-028 rst SHALL override every redirect input in the same cycle, including mid-IDLE and mid-redirect.

Structure
REQ-029 Shared package SHALL hold RESET_PC, the state enum, and EPOCH_W=2.
REQ-030 No sub-module is required; the priority select stays in this module.

Verification
REQ-031 Reset then fetch_ready_i=1 -> cycle1 valid=0; following accepts give pc 1c000000, 1c000004, 1c000008.
REQ-032 fetch_ready_i=0, br_valid_i=1 target 1c000100 -> next pc_o=1c000100, epoch 0->1, valid stays 1.
REQ-033 excp target 1c008000 and br target 1c000200 same cycle -> pc_o=1c008000, epoch +1 only.
REQ-034 idle_valid_i target 1c000040 -> idle_o=1, valid=0 for 10 cycles; intr_i -> next cycle valid=1, pc 1c000040.
REQ-035 pc_o=fffffffc accepted, no bp -> pc_o=00000000; accepted with bp_taken_i target 1c000010 -> 1c000010.
REQ-036 rst asserted during IDLE with excp_valid_i=1 -> pc_o=1c000000, BOOT, epoch 0.
